// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ writeback sources.
// Grants are combinational; the winning write is registered and presented one cycle later.
module gpr_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                         i_clk,
  input  logic                         i_resetn,
  input  logic                         i_hold,
  input  logic [NUM_REQ-1:0]           i_reqValid,
  output logic [NUM_REQ-1:0]           o_reqReady,
  input  logic [NUM_REQ*ADDR_W-1:0]    i_reqAddr,
  input  logic [NUM_REQ*XLEN-1:0]      i_reqData,
  output logic                         o_wrEn,
  output logic [ADDR_W-1:0]            o_wrAddr,
  output logic [XLEN-1:0]              o_wrData,
  output logic [$clog2(NUM_REQ)-1:0]   o_grantId
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam logic [GID_W:0] NUM_REQ_W = (GID_W+1)'(NUM_REQ);
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(NUM_REQ - 1);

  logic [GID_W-1:0]  r_ptr;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [XLEN-1:0]   r_wrData;
  logic [GID_W-1:0]  r_grantId;

  logic [ADDR_W-1:0] w_addrArr [NUM_REQ];
  logic [XLEN-1:0]   w_dataArr [NUM_REQ];
  logic [NUM_REQ-1:0] w_ready;
  logic              w_hs;
  logic [GID_W-1:0]  w_gid;
  logic [GID_W:0]    w_sum;
  logic [GID_W-1:0]  w_idx;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_addrArr[k] = i_reqAddr[k*ADDR_W +: ADDR_W];
    assign w_dataArr[k] = i_reqData[k*XLEN +: XLEN];
  end

  // Scan from the pointer with wrap; the first valid requester wins.
  always_comb begin
    w_ready = '0;
    w_hs    = 1'b0;
    w_gid   = '0;
    w_sum   = '0;
    w_idx   = '0;
    if (i_resetn && !i_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_sum = {1'b0, r_ptr} + (GID_W+1)'(i);
        if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
        w_idx = w_sum[GID_W-1:0];
        if (!w_hs && i_reqValid[w_idx]) begin
          w_hs           = 1'b1;
          w_gid          = w_idx;
          w_ready[w_idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ptr     <= '0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_grantId <= '0;
    end else if (w_hs) begin
      r_ptr     <= (w_gid == LAST_ID) ? '0 : w_gid + 1'b1;
      r_wrEn    <= (w_addrArr[w_gid] != '0);  // x0 writes are accepted but dropped
      r_wrAddr  <= w_addrArr[w_gid];
      r_wrData  <= w_dataArr[w_gid];
      r_grantId <= w_gid;
    end else begin
      r_wrEn    <= 1'b0;
    end
  end

  assign o_reqReady = w_ready;
  assign o_wrEn     = r_wrEn;
  assign o_wrAddr   = r_wrAddr;
  assign o_wrData   = r_wrData;
  assign o_grantId  = r_grantId;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-free behavioural model of round-robin arbitration.
module tb_gpr_wb_arbiter;
  localparam int N  = 3;
  localparam int XW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hold = 1'b0;
  logic [N-1:0] valid = '0;
  logic [AW-1:0] addr [N];
  logic [XW-1:0] data [N];
  logic [N*AW-1:0] addr_p;
  logic [N*XW-1:0] data_p;

  logic [N-1:0]         ready;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XW-1:0]        wr_data;
  logic [$clog2(N)-1:0] grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  always_comb begin
    addr_p = '0;
    data_p = '0;
    for (int k = 0; k < N; k++) begin
      addr_p[k*AW +: AW] = addr[k];
      data_p[k*XW +: XW] = data[k];
    end
  end

  gpr_wb_arbiter #(.NUM_REQ(N), .XLEN(XW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_resetn(rst_n), .i_hold(hold),
    .i_reqValid(valid), .o_reqReady(ready),
    .i_reqAddr(addr_p), .i_reqData(data_p),
    .o_wrEn(wr_en), .o_wrAddr(wr_addr), .o_wrData(wr_data), .o_grantId(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pointer, expected registered write, last grant.
  int            m_ptr = 0;
  logic          m_wrEn = 1'b0;
  logic [AW-1:0] m_wrAddr = '0;
  logic [XW-1:0] m_wrData = '0;
  int            m_gid = 0;
  int            m_last_g = -1;
  int            wcnt [N];

  function automatic int exp_grant();
    if (!rst_n || hold) return -1;
    for (int i = 0; i < N; i++) begin
      if (valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_ptr = 0; m_wrEn = 1'b0; m_wrAddr = '0; m_wrData = '0; m_gid = 0; m_last_g = -1;
    end else begin
      g = exp_grant();
      m_last_g = g;
      if (g >= 0) begin
        m_wrEn   = (addr[g] != 0);
        m_wrAddr = addr[g];
        m_wrData = data[g];
        m_gid    = g;
        m_ptr    = (g + 1) % N;
      end else begin
        m_wrEn = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("m_ready",   64'(ready),    64'(er));
    chk("m_wrEn",    64'(wr_en),    64'(m_wrEn));
    chk("m_wrAddr",  64'(wr_addr),  64'(m_wrAddr));
    chk("m_wrData",  64'(wr_data),  64'(m_wrData));
    chk("m_grantId", 64'(grant_id), 64'(m_gid));
    for (int k = 0; k < N; k++) begin
      if (!valid[k] || ready[k]) wcnt[k] = 0;
      else if (ready != '0) wcnt[k] = wcnt[k] + 1;
      n_tests++;
      if (wcnt[k] >= N) begin
        n_fail++;
        $display("FAIL fairness: requester %0d passed over %0d times, limit %0d", k, wcnt[k], N - 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      addr[k] = '0; data[k] = '0; wcnt[k] = 0;
    end
    #2 rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    // Round-robin with all three valid
    valid = 3'b111;
    addr[0] = 5'd1; addr[1] = 5'd2; addr[2] = 5'd3;
    data[0] = 32'h100; data[1] = 32'h101; data[2] = 32'h102;
    @(negedge clk); chk("rr_first_grant", 64'(ready), 64'(3'b001));
    step();
    @(negedge clk); chk("rr_ready1", 64'(ready), 64'(3'b010)); chk("rr_addr1", 64'(wr_addr), 64'd1);
    step();
    @(negedge clk); chk("rr_ready2", 64'(ready), 64'(3'b100)); chk("rr_addr2", 64'(wr_addr), 64'd2);
    step();
    @(negedge clk); chk("rr_ready3", 64'(ready), 64'(3'b001)); chk("rr_addr3", 64'(wr_addr), 64'd3);
    chk("rr_gid3", 64'(grant_id), 64'd2);
    step(); valid = '0;
    @(negedge clk); chk("rr_addr4", 64'(wr_addr), 64'd1); chk("rr_wrEn4", 64'(wr_en), 64'd1);
    // Single request from requester 1
    step(); valid = 3'b010; addr[1] = 5'd7; data[1] = 32'hDEAD_BEEF;
    @(negedge clk); chk("single_ready", 64'(ready), 64'(3'b010));
    step(); valid = '0;
    @(negedge clk);
    chk("single_wrEn", 64'(wr_en), 64'd1); chk("single_addr", 64'(wr_addr), 64'd7);
    chk("single_data", 64'(wr_data), 64'hDEAD_BEEF); chk("single_gid", 64'(grant_id), 64'd1);
    // x0 write is accepted but not issued
    step(); valid = 3'b100; addr[2] = 5'd0; data[2] = 32'h1234;
    @(negedge clk); chk("x0_ready", 64'(ready), 64'(3'b100));
    step(); valid = '0;
    @(negedge clk); chk("x0_wrEn", 64'(wr_en), 64'd0); chk("x0_gid", 64'(grant_id), 64'd2);
    step(); valid = 3'b101; addr[0] = 5'd9;
    @(negedge clk); chk("x0_ptr_wrap", 64'(ready), 64'(3'b001));
    step(); valid = '0;
    @(negedge clk); chk("x0_next_wr", 64'(wr_addr), 64'd9);
    // Hold blocks grants
    step(); hold = 1'b1; valid = 3'b001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("hold_ready", 64'(ready), 64'd0); chk("hold_wrEn", 64'(wr_en), 64'd0);
      step();
    end
    hold = 1'b0;
    @(negedge clk); chk("unhold_ready", 64'(ready), 64'(3'b001));
    step(); valid = '0;
    @(negedge clk); chk("unhold_wrEn", 64'(wr_en), 64'd1); chk("unhold_gid", 64'(grant_id), 64'd0);
    // Withdrawn request leaves no trace
    step(); valid = 3'b100;
    @(negedge clk); chk("wd_pre", 64'(ready), 64'(3'b100));
    step(); valid = 3'b011;
    @(negedge clk); chk("wd_grant0", 64'(ready), 64'(3'b001));
    step(); valid = 3'b110;
    @(negedge clk); chk("wd_ptr1", 64'(ready), 64'(3'b010)); chk("wd_gid", 64'(grant_id), 64'd0);
    step(); valid = '0;
    @(negedge clk); chk("wd_gid1", 64'(grant_id), 64'd1);
    // Async reset mid-write
    step(); valid = 3'b001; addr[0] = 5'd17;
    step(); valid = '0;
    @(negedge clk); chk("rst_pre_wrEn", 64'(wr_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wrEn", 64'(wr_en), 64'd0); chk("rst_wrAddr", 64'(wr_addr), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0); chk("rst_wrData", 64'(wr_data), 64'd0);
    valid = 3'b111;
    #1 chk("rst_ready", 64'(ready), 64'd0);
    step(); rst_n = 1'b1;
    @(negedge clk); chk("rst_first_grant", 64'(ready), 64'(3'b001));
    // Hold rising mid-stream
    step(); hold = 1'b1;
    @(negedge clk); chk("hrise_ready", 64'(ready), 64'd0); chk("hrise_wrEn", 64'(wr_en), 64'd1);
    step();
    @(negedge clk); chk("hrise_wrEn2", 64'(wr_en), 64'd0);
    step(); hold = 1'b0; valid = '0;
    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1503) rst_n = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (!valid[k] || m_last_g == k) begin
          valid[k] = 1'($urandom_range(0, 1));
          addr[k]  = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
          data[k]  = XW'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          valid[k] = 1'b0;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
